// File: rtl/bb_sgpio_tx_gen_if.sv
// SGPIO initiator bundle: host-side LED requests and capture results plus the serial bus pins.
interface bb_sgpio_tx_gen_if #(
   parameter int NUM_DRV = 36
);
   logic                   EN;
   logic [NUM_DRV-1:0]     ACT_LED;
   logic [NUM_DRV-1:0]     LOC_LED;
   logic [NUM_DRV-1:0]     FAIL_LED;
   logic                   SGPIO_DIN;
   logic                   SGPIO_CK;
   logic                   SGPIO_LD;
   logic                   SGPIO_DATA;
   logic [3*NUM_DRV-1:0]   DIN_BITS;
   logic                   FRAME_DONE;

   modport master (
      input  EN, ACT_LED, LOC_LED, FAIL_LED, SGPIO_DIN,
      output SGPIO_CK, SGPIO_LD, SGPIO_DATA, DIN_BITS, FRAME_DONE
   );

   modport slave (
      output EN, ACT_LED, LOC_LED, FAIL_LED, SGPIO_DIN,
      input  SGPIO_CK, SGPIO_LD, SGPIO_DATA, DIN_BITS, FRAME_DONE
   );
endinterface

// File: rtl/bb_sgpio_tx_gen.sv
// SGPIO initiator: serialises ACT/LOC/FAIL per drive onto SClock/SLoad/SDataOut
// and captures the returning SDataIn frame into DIN_BITS.
module bb_sgpio_tx_gen #(
   parameter int NUM_DRV = 36,
   parameter int CLK_DIV = 250
) (
   input  logic               SYSCLK,
   input  logic               RESET_N,
   bb_sgpio_tx_gen_if.master  bus
);
   localparam int NSLOT = 3 * NUM_DRV;
   localparam int SW    = $clog2(NSLOT);
   localparam int DW    = $clog2(CLK_DIV);
   localparam logic [SW-1:0] LAST_SLOT = SW'(NSLOT - 1);
   localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, next_state;
   logic [DW-1:0]     div_cnt;
   logic [SW-1:0]     slot;
   logic              ck_q, ld_q, data_q, done_q;
   logic [NSLOT-1:0]  shift_q, capture_q, din_bits_q, snap;
   logic              tick, ck_rise, ck_fall, frame_end, start_frame;

   // Slot 3*i+j carries drive i: j=0 activity, j=1 locate, j=2 fail.
   always_comb begin
      snap = '0;
      for (int i = 0; i < NUM_DRV; i++) begin
         snap[3*i]   = bus.ACT_LED[i];
         snap[3*i+1] = bus.LOC_LED[i];
         snap[3*i+2] = bus.FAIL_LED[i];
      end
   end

   always_comb begin
      tick        = (state == RUN) && (div_cnt == DIV_MAX);
      ck_rise     = tick && !ck_q;
      ck_fall     = tick && ck_q;
      frame_end   = ck_fall && (slot == LAST_SLOT);
      start_frame = bus.EN && ((state == IDLE) || frame_end);
      next_state  = state;
      case (state)
         IDLE:    if (bus.EN) next_state = RUN;
         RUN:     if (frame_end && !bus.EN) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= next_state;
   end

   // A frame that ends with EN low drops straight back to the all-zero idle bus;
   // otherwise the next slot 0 is presented on the same edge with no gap.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         div_cnt    <= '0;
         slot       <= '0;
         ck_q       <= 1'b0;
         ld_q       <= 1'b0;
         data_q     <= 1'b0;
         done_q     <= 1'b0;
         shift_q    <= '0;
         capture_q  <= '0;
         din_bits_q <= '0;
      end else begin
         done_q <= frame_end;
         if (state == IDLE || tick) div_cnt <= '0;
         else                       div_cnt <= div_cnt + 1'b1;
         if (tick)      ck_q <= ~ck_q;
         if (ck_rise)   capture_q[slot] <= bus.SGPIO_DIN;
         if (frame_end) din_bits_q <= capture_q;
         if (start_frame) begin
            slot    <= '0;
            shift_q <= snap;
            data_q  <= snap[0];
            ld_q    <= 1'b1;
         end else if (frame_end) begin
            slot   <= '0;
            data_q <= 1'b0;
            ld_q   <= 1'b0;
         end else if (ck_fall) begin
            slot    <= slot + 1'b1;
            shift_q <= shift_q >> 1;
            data_q  <= shift_q[1];
            ld_q    <= 1'b0;
         end
      end
   end

   assign bus.SGPIO_CK   = ck_q;
   assign bus.SGPIO_LD   = ld_q;
   assign bus.SGPIO_DATA = data_q;
   assign bus.DIN_BITS   = din_bits_q;
   assign bus.FRAME_DONE = done_q;
endmodule

// File: tb/tb_bb_sgpio_tx_gen.sv
// Randomised bench for bb_sgpio_tx_gen: a bus monitor rebuilds each frame and
// compares it against the LED snapshot and the target's SDataIn pattern.
module tb_bb_sgpio_tx_gen;
   localparam int NDRV = 4;
   localparam int CDIV = 4;
   localparam int NS   = 3 * NDRV;

   logic SYSCLK;
   logic RESET_N;

   bb_sgpio_tx_gen_if #(.NUM_DRV(NDRV)) bus_if ();

   bb_sgpio_tx_gen #(.NUM_DRV(NDRV), .CLK_DIV(CDIV)) dut (
      .SYSCLK  (SYSCLK),
      .RESET_N (RESET_N),
      .bus     (bus_if)
   );

   initial SYSCLK = 1'b0;
   always #5 SYSCLK = ~SYSCLK;

   int n_checks = 0;
   int n_fail   = 0;

   int cyc = 0, start_cyc = 0, last_rise = 0, done_count = 0;
   int slot_idx = 0, cur_n = 0;
   int period_err = 0, done_width_err = 0, din_hold_err = 0;
   logic in_frame = 1'b0, have_rise = 1'b0, fixed_din = 1'b1;
   logic prev_ck = 1'b0, prev_ld = 1'b0, prev_done = 1'b0;
   logic [NS-1:0] cur_data, cur_ld, cur_snap, cur_din, last_data, din_hold, prev_led;
   logic [NDRV-1:0] act_v, loc_v, fail_v;

   task automatic checkOutput(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Expected SDataOut frame from the LED vectors latched at frame start.
   function automatic logic [NS-1:0] frame_model(input logic [NS-1:0] s);
      logic [NS-1:0] r;
      r = '0;
      for (int k = 0; k < NS; k++) r[k] = s[(k % 3) * NDRV + k / 3];
      return r;
   endfunction

   task automatic applyStimulus(input logic en, input logic [NDRV-1:0] a,
                                input logic [NDRV-1:0] l, input logic [NDRV-1:0] f);
      @(posedge SYSCLK);
      #1;
      act_v = a; loc_v = l; fail_v = f;
      bus_if.EN       = en;
      bus_if.ACT_LED  = a;
      bus_if.LOC_LED  = l;
      bus_if.FAIL_LED = f;
   endtask

   task automatic waitDone();
      int c0;
      c0 = done_count;
      for (int k = 0; k < 1000; k++) begin
         @(negedge SYSCLK);
         #1;
         if (done_count != c0) return;
      end
      checkOutput("wait_done_timeout", 0, 1);
   endtask

   task automatic waitSlot(input int s);
      for (int k = 0; k < 1000; k++) begin
         @(negedge SYSCLK);
         #1;
         if (in_frame && slot_idx == s) return;
      end
      checkOutput("wait_slot_timeout", 0, 1);
   endtask

   // Bus monitor and SDataIn target model, sampled mid-cycle.
   always @(negedge SYSCLK) begin
      cyc++;
      if (!RESET_N) begin
         in_frame  = 1'b0;
         have_rise = 1'b0;
         din_hold  = '0;
         prev_ck   = 1'b0;
         prev_ld   = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (bus_if.FRAME_DONE && prev_done) done_width_err++;
         if (!bus_if.FRAME_DONE && bus_if.DIN_BITS !== din_hold) din_hold_err++;
         if (bus_if.SGPIO_CK && !prev_ck) begin
            if (have_rise && (cyc - last_rise) != 2 * CDIV) period_err++;
            have_rise = 1'b1;
            last_rise = cyc;
            if (in_frame) begin
               if (cur_n < NS) begin
                  cur_data[cur_n] = bus_if.SGPIO_DATA;
                  cur_ld[cur_n]   = bus_if.SGPIO_LD;
               end
               cur_n++;
            end
         end
         if (!bus_if.SGPIO_CK && prev_ck && in_frame) begin
            slot_idx++;
            if (slot_idx < NS) bus_if.SGPIO_DIN = cur_din[slot_idx];
         end
         if (bus_if.FRAME_DONE) begin
            done_count++;
            checkOutput("done_in_frame", int'(in_frame), 1);
            if (in_frame) begin
               checkOutput("frame_data", int'(cur_data), int'(frame_model(cur_snap)));
               checkOutput("frame_ld", int'(cur_ld), 1);
               checkOutput("frame_slots", cur_n, NS);
               checkOutput("frame_len", cyc - start_cyc, NS * 2 * CDIV);
               checkOutput("din_bits", int'(bus_if.DIN_BITS), int'(cur_din));
               last_data = cur_data;
            end
            din_hold = bus_if.DIN_BITS;
            in_frame = 1'b0;
         end
         if (bus_if.SGPIO_LD && !prev_ld) begin
            if (!bus_if.FRAME_DONE) have_rise = 1'b0;
            in_frame  = 1'b1;
            start_cyc = cyc;
            cur_snap  = prev_led;
            cur_n     = 0;
            cur_data  = '0;
            cur_ld    = '0;
            slot_idx  = 0;
            cur_din   = fixed_din ? NS'(12'hAAA) : (NS'($urandom) | NS'(1));
            bus_if.SGPIO_DIN = cur_din[0];
         end
         prev_ck   = bus_if.SGPIO_CK;
         prev_ld   = bus_if.SGPIO_LD;
         prev_done = bus_if.FRAME_DONE;
      end
      prev_led = {bus_if.FAIL_LED, bus_if.LOC_LED, bus_if.ACT_LED};
   end

   initial begin
      int n, idle_err, c0;
      RESET_N = 1'b0;
      bus_if.EN = 1'b0;
      bus_if.ACT_LED = '1; bus_if.LOC_LED = '1; bus_if.FAIL_LED = '1;
      act_v = '1; loc_v = '1; fail_v = '1;
      bus_if.SGPIO_DIN = 1'b0;
      #12;
      checkOutput("reset_ck", int'(bus_if.SGPIO_CK), 0);
      checkOutput("reset_ld", int'(bus_if.SGPIO_LD), 0);
      checkOutput("reset_data", int'(bus_if.SGPIO_DATA), 0);
      checkOutput("reset_din_bits", int'(bus_if.DIN_BITS), 0);
      checkOutput("reset_done", int'(bus_if.FRAME_DONE), 0);
      @(posedge SYSCLK);
      #1 RESET_N = 1'b1;

      idle_err = 0;
      repeat (200) begin
         @(negedge SYSCLK);
         if (bus_if.SGPIO_CK || bus_if.SGPIO_LD || bus_if.SGPIO_DATA) idle_err++;
      end
      checkOutput("idle_outputs", idle_err, 0);
      checkOutput("idle_done_count", done_count, 0);
      checkOutput("idle_din_bits", int'(bus_if.DIN_BITS), 0);

      applyStimulus(1'b1, 4'b0001, 4'b0010, 4'b1000);
      @(posedge SYSCLK);
      #1;
      checkOutput("start_ld", int'(bus_if.SGPIO_LD), 1);
      checkOutput("start_data", int'(bus_if.SGPIO_DATA), 1);
      checkOutput("start_ck", int'(bus_if.SGPIO_CK), 0);
      n = 0;
      for (int k = 1; k <= 4 * CDIV; k++) begin
         @(posedge SYSCLK);
         #1;
         if (bus_if.SGPIO_CK) begin
            n = k;
            break;
         end
      end
      checkOutput("first_rise_delay", n, CDIV);
      waitDone();
      checkOutput("bit_order", int'(last_data), 12'h811);
      checkOutput("first_din_bits", int'(bus_if.DIN_BITS), 12'hAAA);
      fixed_din = 1'b0;

      // Frame 2 is already under way; wiggle ACT[3] so only the latched value counts.
      for (int k = 0; k < 25; k++) begin
         applyStimulus(1'b1, act_v ^ 4'b1000, loc_v, fail_v);
         repeat (2) @(posedge SYSCLK);
      end
      waitDone();
      checkOutput("snap_slot9_f2", int'(last_data[9]), 0);
      waitDone();
      checkOutput("snap_slot9_f3", int'(last_data[9]), 1);

      for (int f = 0; f < 6; f++) begin
         repeat ($urandom_range(1, 150)) @(posedge SYSCLK);
         applyStimulus(1'b1, NDRV'($urandom), NDRV'($urandom), NDRV'($urandom));
      end
      waitDone();

      waitSlot(5);
      c0 = done_count;
      applyStimulus(1'b0, act_v, loc_v, fail_v);
      waitDone();
      idle_err = 0;
      repeat (100) begin
         @(negedge SYSCLK);
         if (bus_if.SGPIO_CK || bus_if.SGPIO_LD || bus_if.SGPIO_DATA) idle_err++;
      end
      checkOutput("en_drop_frames", done_count - c0, 1);
      checkOutput("en_drop_idle", idle_err, 0);

      applyStimulus(1'b1, NDRV'($urandom), NDRV'($urandom), NDRV'($urandom));
      @(posedge SYSCLK);
      #1;
      checkOutput("restart_ld", int'(bus_if.SGPIO_LD), 1);
      checkOutput("restart_data", int'(bus_if.SGPIO_DATA), int'(act_v[0]));

      waitSlot(7);
      @(posedge SYSCLK);
      #3 RESET_N = 1'b0;
      #1;
      checkOutput("rst_ck", int'(bus_if.SGPIO_CK), 0);
      checkOutput("rst_ld", int'(bus_if.SGPIO_LD), 0);
      checkOutput("rst_data", int'(bus_if.SGPIO_DATA), 0);
      checkOutput("rst_din_bits", int'(bus_if.DIN_BITS), 0);
      repeat (2) @(posedge SYSCLK);
      #1 RESET_N = 1'b1;
      @(posedge SYSCLK);
      #1;
      checkOutput("rst_restart_ld", int'(bus_if.SGPIO_LD), 1);
      checkOutput("rst_restart_data", int'(bus_if.SGPIO_DATA), int'(act_v[0]));
      waitDone();
      waitDone();

      checkOutput("ck_period", period_err, 0);
      checkOutput("done_width", done_width_err, 0);
      checkOutput("din_bits_hold", din_hold_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
